// File: rtl/rt_word_loader_if.sv
// -----------------------------------------------------------------------------
// rt_word_loader_if
// Purpose : Bundles the word stream coming from the secondary-input stage and
//           the registered bank read port used by the Montgomery multiplier.
// Signals :
//   in_valid  - qualifies r_word/t_word in the current cycle
//   r_word    - next word of r, most-significant word first
//   t_word    - next word of t, most-significant word first
//   rd_en     - read request
//   rd_addr   - word index to read, 0 = least-significant word
//   rd_r      - r bank read data (registered)
//   rd_t      - t bank read data (registered)
//   rd_valid  - high the cycle after rd_en
// Modports:
//   master - the side driving the stream and issuing reads
//   slave  - the loader itself
// -----------------------------------------------------------------------------
interface rt_word_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] r_word;
  logic [DATA_WIDTH-1:0] t_word;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_r;
  logic [DATA_WIDTH-1:0] rd_t;
  logic                  rd_valid;

  modport master (
    output in_valid, r_word, t_word, rd_en, rd_addr,
    input  rd_r, rd_t, rd_valid
  );

  modport slave (
    input  in_valid, r_word, t_word, rd_en, rd_addr,
    output rd_r, rd_t, rd_valid
  );
endinterface

// File: rtl/rt_word_loader.sv
// -----------------------------------------------------------------------------
// rt_word_loader
// Purpose : Captures the Montgomery constants r and t (32 x 32-bit words each,
//           streamed MSW first) plus n0', stores r and t in two word-addressed
//           banks indexed by significance, and serves them over a registered
//           read port. Tracks load completion and flags stream overruns.
// Ports   :
//   clk            - system clock, rising edge
//   reset          - synchronous, active-high
//   start_transfer - one-cycle pulse; arms a new load and latches n0p_in
//   n0p_in         - n0' value, sampled with start_transfer
//   bus            - stream input and bank read port (slave side)
//   n0p            - latched n0'
//   busy           - high while a load is in progress
//   loaded         - high when both banks hold a complete operand
//   overflow       - sticky; a word arrived while no load was active
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no load armed; stray words set overflow
// S_LOAD  | accepting words, word_cnt counts words received so far
// S_READY | banks hold a complete operand; stray words set overflow
// -----------------------------------------------------------------------------
module rt_word_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_transfer,
  input  logic [DATA_WIDTH-1:0] n0p_in,
  rt_word_loader_if.slave       bus,
  output logic [DATA_WIDTH-1:0] n0p,
  output logic                  busy,
  output logic                  loaded,
  output logic                  overflow
);

  localparam int                    NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_word_cnt;
  logic [DATA_WIDTH-1:0] r_n0p;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_rd_r;
  logic [DATA_WIDTH-1:0] r_rd_t;
  logic                  r_rd_valid;

  logic [DATA_WIDTH-1:0] r_rbank [NUM_WORDS];
  logic [DATA_WIDTH-1:0] r_tbank [NUM_WORDS];

  logic                  w_wr_en;
  logic                  w_last_word;
  logic [ADDR_WIDTH-1:0] w_wr_addr;

  // A start pulse takes priority: a word arriving in the same cycle is dropped.
  assign w_wr_en     = (r_state == S_LOAD) && bus.in_valid && !start_transfer;
  assign w_last_word = (r_word_cnt == LAST_IDX);
  // The k-th word received is the k-th most significant, so it lands at 31-k.
  assign w_wr_addr   = LAST_IDX - r_word_cnt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (start_transfer) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_LOAD:  if (w_wr_en && w_last_word) w_state_nxt = S_READY;
        S_READY: w_state_nxt = S_READY;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded straight from the state register)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (r_state == S_LOAD);
    loaded = (r_state == S_READY);
  end

  // ---------------------------------------------------------------------------
  // Word counter, n0' latch and overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_cnt <= '0;
      r_n0p      <= '0;
      r_overflow <= 1'b0;
    end else if (start_transfer) begin
      r_word_cnt <= '0;
      r_n0p      <= n0p_in;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
      end
      if (bus.in_valid && (r_state != S_LOAD)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register banks: no reset, contents only meaningful after a completed load
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_rbank[w_wr_addr] <= bus.r_word;
      r_tbank[w_wr_addr] <= bus.t_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port. Sampling the banks at the same edge as a write
  // returns the pre-write contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_r     <= '0;
      r_rd_t     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_r <= r_rbank[bus.rd_addr];
        r_rd_t <= r_tbank[bus.rd_addr];
      end
    end
  end

  assign bus.rd_r     = r_rd_r;
  assign bus.rd_t     = r_rd_t;
  assign bus.rd_valid = r_rd_valid;
  assign n0p          = r_n0p;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_rt_word_loader.sv
// -----------------------------------------------------------------------------
// tb_rt_word_loader
// Purpose : Directed self-checking bench for rt_word_loader. Inputs change 1 ns
//           after each rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_rt_word_loader;

  logic        clk;
  logic        reset;
  logic        start_transfer;
  logic [31:0] n0p_in;
  logic [31:0] n0p;
  logic        busy;
  logic        loaded;
  logic        overflow;

  int total;
  int bad;
  int busy_cycles;

  rt_word_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  rt_word_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_transfer (start_transfer),
    .n0p_in         (n0p_in),
    .bus            (bus),
    .n0p            (n0p),
    .busy           (busy),
    .loaded         (loaded),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [31:0] exp_r,
                         input logic [31:0] exp_t, input string tag);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    tick();
    bus.rd_en = 1'b0;
    check({tag, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
    check({tag, "_r"}, bus.rd_r, exp_r);
    check({tag, "_t"}, bus.rd_t, exp_t);
    tick();
    check({tag, "_valid_drop"}, {31'd0, bus.rd_valid}, 32'd0);
    check({tag, "_r_hold"}, bus.rd_r, exp_r);
  endtask

  task automatic pulse_start(input logic [31:0] val);
    start_transfer = 1'b1;
    n0p_in         = val;
    tick();
    start_transfer = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] rv, input logic [31:0] tv);
    bus.in_valid = 1'b1;
    bus.r_word   = rv;
    bus.t_word   = tv;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    start_transfer = 1'b0;
    n0p_in         = '0;
    bus.in_valid   = 1'b0;
    bus.r_word     = '0;
    bus.t_word     = '0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_loaded", {31'd0, loaded}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("rst_n0p", n0p, 32'd0);
    check("rst_rd_r", bus.rd_r, 32'd0);
    check("rst_rd_t", bus.rd_t, 32'd0);

    // Scenario 1: back-to-back load
    pulse_start(32'hDEADBEEF);
    check("s1_n0p", n0p, 32'hDEADBEEF);
    busy_cycles = 0;
    for (int k = 0; k < 32; k++) begin
      if (busy) busy_cycles++;
      send_word(32'(k), 32'h1000_0000 + 32'(k));
    end
    check("s1_busy_cycles", 32'(busy_cycles), 32'd32);
    check("s1_loaded", {31'd0, loaded}, 32'd1);
    check("s1_busy_done", {31'd0, busy}, 32'd0);
    do_read(5'd31, 32'd0, 32'h1000_0000, "s1_rd31");
    do_read(5'd0, 32'd31, 32'h1000_001F, "s1_rd0");
    do_read(5'd15, 32'd16, 32'h1000_0010, "s1_rd15");

    // Scenario 2: gapped load
    pulse_start(32'h1234_5678);
    check("s2_n0p", n0p, 32'h1234_5678);
    check("s2_loaded_clr", {31'd0, loaded}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      if (k == 31) check("s2_loaded_before_last", {31'd0, loaded}, 32'd0);
      send_word(32'(k), 32'h1000_0000 + 32'(k));
      tick();
    end
    check("s2_loaded", {31'd0, loaded}, 32'd1);
    do_read(5'd31, 32'd0, 32'h1000_0000, "s2_rd31");
    do_read(5'd0, 32'd31, 32'h1000_001F, "s2_rd0");
    do_read(5'd7, 32'd24, 32'h1000_0018, "s2_rd7");

    // Scenario 3: overrun after completion
    send_word(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("s3_overflow", {31'd0, overflow}, 32'd1);
    check("s3_loaded_kept", {31'd0, loaded}, 32'd1);
    tick();
    tick();
    check("s3_overflow_sticky", {31'd0, overflow}, 32'd1);
    do_read(5'd0, 32'd31, 32'h1000_001F, "s3_rd0");
    pulse_start(32'h0);
    check("s3_overflow_clr", {31'd0, overflow}, 32'd0);
    check("s3_busy", {31'd0, busy}, 32'd1);

    // Scenario 4: restart mid-load with a coincident word
    for (int k = 0; k < 10; k++) send_word(32'h50 + 32'(k), 32'h60 + 32'(k));
    start_transfer = 1'b1;
    n0p_in         = 32'hCAFE_0004;
    bus.in_valid   = 1'b1;
    bus.r_word     = 32'h0000_0BAD;
    bus.t_word     = 32'h0000_0BAD;
    tick();
    start_transfer = 1'b0;
    bus.in_valid   = 1'b0;
    check("s4_n0p", n0p, 32'hCAFE_0004);
    check("s4_overflow", {31'd0, overflow}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      if (k == 31) check("s4_loaded_before_last", {31'd0, loaded}, 32'd0);
      send_word(32'hA0 + 32'(k), 32'hB0 + 32'(k));
    end
    check("s4_loaded", {31'd0, loaded}, 32'd1);
    do_read(5'd31, 32'hA0, 32'hB0, "s4_rd31");
    do_read(5'd0, 32'hBF, 32'hCF, "s4_rd0");

    // Scenario 5: reset mid-load, then stray word
    pulse_start(32'h5555_5555);
    for (int k = 0; k < 20; k++) send_word(32'hC0 + 32'(k), 32'hD0 + 32'(k));
    check("s5_busy_mid", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s5_busy", {31'd0, busy}, 32'd0);
    check("s5_loaded", {31'd0, loaded}, 32'd0);
    check("s5_n0p", n0p, 32'd0);
    send_word(32'hFFFF_FFFF, 32'hEEEE_EEEE);
    check("s5_overflow", {31'd0, overflow}, 32'd1);
    check("s5_busy_after", {31'd0, busy}, 32'd0);
    do_read(5'd31, 32'hC0, 32'hD0, "s5_rd31");
    do_read(5'd11, 32'hB4, 32'hC4, "s5_rd11");

    // Scenario 6: read-before-write at address 31
    pulse_start(32'h0);
    for (int k = 0; k < 32; k++) send_word(32'(k), 32'h1000_0000 + 32'(k));
    check("s6_loaded", {31'd0, loaded}, 32'd1);
    pulse_start(32'h0);
    bus.rd_en    = 1'b1;
    bus.rd_addr  = 5'd31;
    bus.in_valid = 1'b1;
    bus.r_word   = 32'h77;
    bus.t_word   = 32'h88;
    tick();
    bus.in_valid = 1'b0;
    check("s6_rbw_r", bus.rd_r, 32'd0);
    check("s6_rbw_t", bus.rd_t, 32'h1000_0000);
    tick();
    bus.rd_en = 1'b0;
    check("s6_new_r", bus.rd_r, 32'h77);
    check("s6_new_t", bus.rd_t, 32'h88);
    check("s6_busy", {31'd0, busy}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
